memory_responder: RTL and testbench

//  Memory-side responder for the datapath MAR/MDR interface. It replaces bench-driven

---
 rtl/memory_responder.sv | 119 +++++++++++
 tb/tb_memory_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed RAM responder for the MAR/MDR datapath, four-phase handshake.
// Define MEM_ERR_EN to add mem_err and treat read&write as a protocol error.
module memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 3
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mem_done,
`ifdef MEM_ERR_EN
  output logic                  mem_err,
`endif
  output logic                  busy
);

  localparam int CW    = $clog2(LATENCY + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  bad_q, bad_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mdat_q, mdat_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic acc;
  logic do_rd;
  logic do_wr;

  // The access edge is the one where the wait counter reaches its last tick.
  assign acc   = (state_q == S_BUSY) && (cnt_q == CW'(1));
  assign do_rd = acc & rd_q & ~bad_q;
  assign do_wr = acc & ~rd_q & ~bad_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      bad_q   <= bad_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mdat_q  <= mdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    bad_d   = bad_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mdat_d  = mdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (read | write) begin
          state_d = S_BUSY;
          cnt_d   = CW'(LATENCY);
          rd_d    = read;
          addr_d  = address;
          data_d  = data_in;
`ifdef MEM_ERR_EN
          bad_d   = read & write;
`else
          bad_d   = 1'b0;
`endif
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (acc) state_d = S_DONE;
      end
      S_DONE: begin
        if (!read && !write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_rd) mdat_d = mem[addr_q];
  end

  // No reset on the array; clear only blocks a pending write.
  always_ff @(posedge clock) begin
    if (do_wr && !clear) mem[addr_q] <= data_q;
  end

  always_comb begin
    busy     = (state_q == S_BUSY);
    mem_done = (state_q == S_DONE);
    Mdatain  = mdat_q;
`ifdef MEM_ERR_EN
    mem_err  = (state_q == S_DONE) & bad_q;
`endif
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (LATENCY 3 and 1) on shared stimulus,
// checked every cycle against a transaction-level model.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [8:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] md0, md1;
  logic        done0, done1, bsy0, bsy1;
`ifdef MEM_ERR_EN
  logic        err0, err1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .LATENCY(3)
  ) dut0 (
    .clock(clk), .clear(clear), .read(read), .write(write),
    .address(address), .data_in(data_in), .Mdatain(md0),
    .mem_done(done0),
`ifdef MEM_ERR_EN
    .mem_err(err0),
`endif
    .busy(bsy0)
  );

  memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .LATENCY(1)
  ) dut1 (
    .clock(clk), .clear(clear), .read(read), .write(write),
    .address(address), .data_in(data_in), .Mdatain(md1),
    .mem_done(done1),
`ifdef MEM_ERR_EN
    .mem_err(err1),
`endif
    .busy(bsy1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // Model: per instance, a pending access fires lat(i) edges after accept.
  logic [31:0] m_ram [2][512];
  bit          m_act [2];
  bit          m_done[2];
  bit          m_rd  [2];
  bit          m_bad [2];
  int          m_left[2];
  logic [8:0]  m_a   [2];
  logic [31:0] m_d   [2];
  logic [31:0] m_md  [2];

  always @(posedge clk or posedge clear) begin
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
        m_bad[i]  = 1'b0;
        m_md[i]   = '0;
      end else if (m_act[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
          if (!m_bad[i]) begin
            if (m_rd[i]) m_md[i] = m_ram[i][m_a[i]];
            else         m_ram[i][m_a[i]] = m_d[i];
          end
        end
      end else if (m_done[i]) begin
        if (!read && !write) begin
          m_done[i] = 1'b0;
          m_bad[i]  = 1'b0;
        end
      end else if (read || write) begin
        m_act[i]  = 1'b1;
        m_left[i] = lat(i);
        m_rd[i]   = read;
        m_a[i]    = address;
        m_d[i]    = data_in;
`ifdef MEM_ERR_EN
        m_bad[i]  = read && write;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("busy_l3", 32'(bsy0), 32'(m_act[0]));
    chk("busy_l1", 32'(bsy1), 32'(m_act[1]));
    chk("done_l3", 32'(done0), 32'(m_done[0]));
    chk("done_l1", 32'(done1), 32'(m_done[1]));
    chk("mdat_l3", md0, m_md[0]);
    chk("mdat_l1", md1, m_md[1]);
`ifdef MEM_ERR_EN
    chk("err_l3", 32'(err0), 32'(m_done[0] && m_bad[0]));
    chk("err_l1", 32'(err1), 32'(m_done[1] && m_bad[1]));
`endif
  end

  task automatic txn(input bit r, input bit w, input logic [8:0] a,
                     input logic [31:0] d, input int hold, input bit tog,
                     input bit abort, input bit cm, input logic [31:0] xmd);
    int n, f0, f1;
    @(posedge clk);
    #2;
    read = r;
    write = w;
    address = a;
    data_in = d;
    if (abort) begin
      @(posedge clk);
      #2;
      clear = 1'b1;
      #1;
      chk("abort_busy_l3", 32'(bsy0), 32'd0);
      chk("abort_busy_l1", 32'(bsy1), 32'd0);
      chk("abort_mdat_l3", md0, 32'd0);
      read = 1'b0;
      write = 1'b0;
      @(posedge clk);
      #2;
      clear = 1'b0;
      return;
    end
    n = 0;
    f0 = -1;
    f1 = -1;
    while ((f0 < 0 || f1 < 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done0 && f0 < 0) f0 = n - 1;
      if (done1 && f1 < 0) f1 = n - 1;
      if (tog) begin
        address = a + 9'd1;
        data_in = $urandom;
      end
    end
    chk("lat_l3", f0, 32'd3);
    chk("lat_l1", f1, 32'd1);
    if (cm) begin
      chk("rd_mdat_l3", md0, xmd);
      chk("rd_mdat_l1", md1, xmd);
`ifdef MEM_ERR_EN
      chk("err_lit_l3", 32'(err0), 32'(r && w));
`endif
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("hold_done", 32'(done0 & done1), 32'd1);
    end
    @(posedge clk);
    #2;
    read = 1'b0;
    write = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_done_l3", 32'(done0), 32'd0);
    chk("drop_done_l1", 32'(done1), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mdat", md0, 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_busy", 32'(bsy1), 32'd0);
    #1;
    clear = 1'b0;

    for (int a = 0; a < 16; a++)
      txn(1'b0, 1'b1, 9'(a), 32'hA500_0000 | 32'(a), 0, 1'b0, 1'b0, 1'b0, '0);
    for (int a = 504; a < 512; a++)
      txn(1'b0, 1'b1, 9'(a), 32'hA500_0000 | 32'(a), 0, 1'b0, 1'b0, 1'b0, '0);

    txn(1'b0, 1'b1, 9'd5, 32'h0000_000A, 0, 1'b0, 1'b0, 1'b0, '0);
    txn(1'b1, 1'b0, 9'd5, '0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_000A);
    txn(1'b1, 1'b0, 9'd6, '0, 0, 1'b0, 1'b0, 1'b1, 32'hA500_0006);
    txn(1'b1, 1'b0, 9'd5, '0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_000A);
    txn(1'b1, 1'b0, 9'd5, '0, 4, 1'b0, 1'b0, 1'b1, 32'h0000_000A);
    txn(1'b0, 1'b1, 9'd7, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1'b0, '0);
    txn(1'b1, 1'b0, 9'd7, '0, 0, 1'b0, 1'b0, 1'b1, 32'hA500_0007);
    txn(1'b0, 1'b1, 9'd511, 32'h0000_0012, 0, 1'b0, 1'b0, 1'b0, '0);
    txn(1'b1, 1'b0, 9'd511, '0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0012);
`ifdef MEM_ERR_EN
    txn(1'b1, 1'b1, 9'd3, 32'h5555_5555, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0012);
`else
    txn(1'b1, 1'b1, 9'd3, 32'h5555_5555, 0, 1'b0, 1'b0, 1'b1, 32'hA500_0003);
`endif
    txn(1'b1, 1'b0, 9'd3, '0, 0, 1'b0, 1'b0, 1'b1, 32'hA500_0003);

    for (int k = 0; k < 80; k++) begin
      int op;
      int r;
      logic [8:0] a;
      op = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 23));
      a = (r < 16) ? 9'(r) : 9'(488 + r);
      txn(op != 1, op != 0, a, $urandom, int'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
          1'b0, '0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
